uart_rx: RTL

Serial receiver for the UART path: it recovers 8N1 frames from the asynchronous `rx_i` line and delivers each byte to the register file. Its `data_o`/`we_o` pair drives the register file's receive-data input and receive write-enable bit directly. It also reports framing errors and line activity to the control logic.

---
 rtl/uart_rx.sv | 127 ++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// 8N1 serial receiver: 2-FF synchronizer, mid-bit sampling FSM, zero-extended
// byte output with single-cycle write-enable and framing-error pulses.
module uart_rx #(
  parameter int ANCHO        = 32,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic             clk,
  input  logic             rst_i,
  input  logic             rx_i,
  output logic [ANCHO-1:0] data_o,
  output logic             we_o,
  output logic             frame_err_o,
  output logic             busy_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] H_CNT    = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          we_q, we_d;
  logic          ferr_q, ferr_d;
  logic          sync1_q, sync2_q;
  logic          rx_s;

  // Synchronizer flops idle high so reset never looks like a start bit
  always_ff @(posedge clk) begin
    if (rst_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rx_i;
      sync2_q <= sync1_q;
    end
  end

  assign rx_s = sync2_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    we_d    = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (!rx_s) state_d = S_START;
      end
      S_START: begin
        // Start bit re-checked at mid-bit; a high line here was only a glitch
        if (cnt_q == H_CNT) begin
          cnt_d   = '0;
          state_d = rx_s ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s;
          if (idx_q == 3'd7) state_d = S_STOP;
          else               idx_d   = idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        // Leaving at mid-stop-bit leaves half a bit to catch the next start edge
        if (cnt_q == LAST_CNT) begin
          cnt_d   = '0;
          state_d = S_IDLE;
          if (rx_s) begin
            data_d = shift_q;
            we_d   = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      we_q    <= we_d;
      ferr_q  <= ferr_d;
    end
  end

  assign data_o      = {{(ANCHO-8){1'b0}}, data_q};
  assign we_o        = we_q;
  assign frame_err_o = ferr_q;
  assign busy_o      = (state_q != S_IDLE);

endmodule
